// File: rtl/io_xbar_output_port_n.sv
// IO crossbar output port: round-robin arbitration over NUM_IN inputs, route held to tail,
// yummy-credit flow control, registered outputs, optional header stripping with pop reporting.
module io_xbar_output_port_n #(
    parameter int   NUM_IN       = 4,
    parameter int   DATA_WIDTH   = 64,
    parameter int   CREDITS      = 4,
    parameter logic KILL_HEADERS = 1'b0,
    parameter int   LEN_MSB      = 30,
    parameter int   LEN_LSB      = 23,
    parameter int   USER_MSB     = 23,
    parameter int   USER_LSB     = 20,
    parameter int   SENDER_MSB   = 19,
    parameter int   SENDER_LSB   = 10,
    localparam int  CW           = $clog2(CREDITS + 1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_IN-1:0]            route_req_in,
    input  logic [NUM_IN-1:0]            valid_in,
    input  logic [NUM_IN-1:0]            tail_in,
    input  logic [NUM_IN*DATA_WIDTH-1:0] data_in,
    input  logic                         yummy_in,
    output logic [NUM_IN-1:0]            thanks_out,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic                         valid_out,
    output logic                         popped_interrupt_mesg_out,
    output logic                         popped_memory_ack_mesg_out,
    output logic [9:0]                   popped_memory_ack_mesg_out_sender,
    output logic                         ec_wants_to_send_but_cannot,
    output logic [CW-1:0]                credit_count_out
);
    localparam int PW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam int UW = USER_MSB - USER_LSB + 1;
    localparam int LW = LEN_MSB - LEN_LSB + 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                  state, state_nxt;
    logic [PW-1:0]           rr_ptr, cur_route, winner;
    logic                    any_req, hdr_pending;
    logic [CW-1:0]           credit;
    logic [DATA_WIDTH-1:0]   flit;
    logic                    sel_valid, sel_tail, kill, xfer, fwd;
    logic [UW-1:0]           user_f;

    assign flit      = data_in[int'(cur_route)*DATA_WIDTH +: DATA_WIDTH];
    assign sel_valid = valid_in[cur_route];
    assign sel_tail  = tail_in[cur_route];
    assign kill      = KILL_HEADERS & hdr_pending;
    assign xfer      = (state == BUSY) & sel_valid & ((credit != '0) | kill);
    assign fwd       = xfer & ~kill;
    assign user_f    = flit[USER_MSB:USER_LSB];
    assign any_req   = |route_req_in;
    assign credit_count_out = credit;
    assign ec_wants_to_send_but_cannot = (state == BUSY) & sel_valid & (credit == '0) & ~kill;

    // Scan downward so the requester closest above rr_ptr is the last (winning) assignment.
    always_comb begin
        int idx;
        idx    = 0;
        winner = '0;
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_IN) idx = idx - NUM_IN;
            if (route_req_in[idx]) winner = PW'(idx);
        end
    end

    always_comb begin
        state_nxt  = state;
        thanks_out = '0;
        case (state)
            IDLE: if (any_req) state_nxt = BUSY;
            BUSY: if (xfer) begin
                thanks_out[cur_route] = 1'b1;
                if (sel_tail) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            cur_route   <= '0;
            hdr_pending <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && any_req) begin
                cur_route   <= winner;
                rr_ptr      <= (winner == PW'(NUM_IN - 1)) ? '0 : winner + 1'b1;
                hdr_pending <= 1'b1;
            end else if (xfer) begin
                hdr_pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_out <= 1'b0;
            data_out  <= '0;
            credit    <= CW'(CREDITS);
        end else begin
            valid_out <= fwd;
            if (fwd) data_out <= flit;
            // Extra yummy at full credit is a downstream protocol error; just saturate.
            case ({fwd, yummy_in})
                2'b10:   credit <= credit - 1'b1;
                2'b01:   if (credit != CW'(CREDITS)) credit <= credit + 1'b1;
                default: credit <= credit;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            popped_interrupt_mesg_out         <= 1'b0;
            popped_memory_ack_mesg_out        <= 1'b0;
            popped_memory_ack_mesg_out_sender <= '0;
        end else begin
            popped_interrupt_mesg_out         <= 1'b0;
            popped_memory_ack_mesg_out        <= 1'b0;
            popped_memory_ack_mesg_out_sender <= '0;
            if (xfer && kill && flit[LEN_MSB:LEN_LSB] == LW'(0)) begin
                if (user_f == UW'(4'b1111)) popped_interrupt_mesg_out <= 1'b1;
                if (user_f == UW'(4'b1110)) begin
                    popped_memory_ack_mesg_out        <= 1'b1;
                    popped_memory_ack_mesg_out_sender <= 10'(flit[SENDER_MSB:SENDER_LSB]);
                end
            end
        end
    end
endmodule

// File: tb/tb_io_xbar_output_port_n.sv
// Scoreboard bench: three port instances (default, 2-credit, header-kill) share one upstream driver.
module tb_io_xbar_output_port_n;
    typedef struct {logic [63:0] d; logic hdr; logic tail;} flit_t;
    typedef struct {logic intr; logic [9:0] snd;} pop_t;

    logic clk, reset, yummy;
    logic [1:0] sel;
    logic [3:0] req, vld, tl;
    logic [3:0][63:0] dat;

    logic [3:0] thx0, thx1, thx2, thx_s;
    logic [63:0] do0, do1, do2, do_s;
    logic vo0, vo1, vo2, vo_s, pi0, pi1, pi2, pi_s, pm0, pm1, pm2, pm_s;
    logic [9:0] sn0, sn1, sn2, sn_s;
    logic st0, st1, st2;
    logic [2:0] c0, c2;
    logic [1:0] c1;

    flit_t txq[4][$];
    logic [63:0] exp_q[$];
    pop_t exp_pop[$];
    int checks = 0, errors = 0;

    io_xbar_output_port_n u0 (
        .clk(clk), .reset(reset),
        .route_req_in(sel == 0 ? req : 4'b0), .valid_in(sel == 0 ? vld : 4'b0),
        .tail_in(sel == 0 ? tl : 4'b0), .data_in(sel == 0 ? dat : '0),
        .yummy_in(sel == 0 && yummy), .thanks_out(thx0), .data_out(do0), .valid_out(vo0),
        .popped_interrupt_mesg_out(pi0), .popped_memory_ack_mesg_out(pm0),
        .popped_memory_ack_mesg_out_sender(sn0), .ec_wants_to_send_but_cannot(st0),
        .credit_count_out(c0));

    io_xbar_output_port_n #(.CREDITS(2)) u1 (
        .clk(clk), .reset(reset),
        .route_req_in(sel == 1 ? req : 4'b0), .valid_in(sel == 1 ? vld : 4'b0),
        .tail_in(sel == 1 ? tl : 4'b0), .data_in(sel == 1 ? dat : '0),
        .yummy_in(sel == 1 && yummy), .thanks_out(thx1), .data_out(do1), .valid_out(vo1),
        .popped_interrupt_mesg_out(pi1), .popped_memory_ack_mesg_out(pm1),
        .popped_memory_ack_mesg_out_sender(sn1), .ec_wants_to_send_but_cannot(st1),
        .credit_count_out(c1));

    // Length field moved to [30:24] so it no longer overlaps the top user bit.
    io_xbar_output_port_n #(.KILL_HEADERS(1'b1), .LEN_LSB(24)) u2 (
        .clk(clk), .reset(reset),
        .route_req_in(sel == 2 ? req : 4'b0), .valid_in(sel == 2 ? vld : 4'b0),
        .tail_in(sel == 2 ? tl : 4'b0), .data_in(sel == 2 ? dat : '0),
        .yummy_in(sel == 2 && yummy), .thanks_out(thx2), .data_out(do2), .valid_out(vo2),
        .popped_interrupt_mesg_out(pi2), .popped_memory_ack_mesg_out(pm2),
        .popped_memory_ack_mesg_out_sender(sn2), .ec_wants_to_send_but_cannot(st2),
        .credit_count_out(c2));

    always_comb begin
        case (sel)
            2'd1:    begin thx_s = thx1; do_s = do1; vo_s = vo1; pi_s = pi1; pm_s = pm1; sn_s = sn1; end
            2'd2:    begin thx_s = thx2; do_s = do2; vo_s = vo2; pi_s = pi2; pm_s = pm2; sn_s = sn2; end
            default: begin thx_s = thx0; do_s = do0; vo_s = vo0; pi_s = pi0; pm_s = pm0; sn_s = sn0; end
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input int i, input logic [63:0] d, input logic h, input logic t);
        flit_t f;
        f.d = d; f.hdr = h; f.tail = t;
        txq[i].push_back(f);
    endtask

    task automatic cyc();
        @(negedge clk);
        #2;
    endtask

    // Upstream driver: present queue heads at negedge, retire a flit when thanked.
    initial begin
        flit_t f;
        req = '0; vld = '0; tl = '0; dat = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (txq[i].size() > 0) begin
                    f = txq[i][0];
                    req[i] = f.hdr; vld[i] = 1'b1; tl[i] = f.tail; dat[i] = f.d;
                end else begin
                    req[i] = 1'b0; vld[i] = 1'b0; tl[i] = 1'b0; dat[i] = '0;
                end
            end
            #1;
            for (int i = 0; i < 4; i++)
                if (thx_s[i] && txq[i].size() > 0) f = txq[i].pop_front();
        end
    end

    // Monitor: every presented flit or pop pulse must match the scoreboard head.
    initial begin
        logic [63:0] e;
        pop_t p;
        forever begin
            @(negedge clk);
            #3;
            if (vo_s) begin
                if (exp_q.size() == 0) chk("unexpected_flit", do_s, 64'hDEAD);
                else begin e = exp_q.pop_front(); chk("data_out", do_s, e); end
            end
            if (pi_s || pm_s) begin
                if (exp_pop.size() == 0) chk("unexpected_pop", {pi_s, pm_s}, 2'b00);
                else begin
                    p = exp_pop.pop_front();
                    chk("pop_kind", {pi_s, pm_s}, p.intr ? 2'b10 : 2'b01);
                    chk("pop_sender", sn_s, p.intr ? 10'h0 : p.snd);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] rr_thx [10];
        rr_thx = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1};
        reset = 1'b1; sel = 2'd0; yummy = 1'b0;
        repeat (2) cyc();
        reset = 1'b0;
        cyc();
        chk("rst_valid", vo0, 0);
        chk("rst_data", do0, 0);
        chk("rst_thanks", thx0, 0);
        chk("rst_credit0", c0, 4);
        chk("rst_credit1", c1, 2);
        chk("rst_stall", st0, 0);
        chk("rst_pops", {pi2, pm2, sn2}, 0);

        // Single 3-flit packet from input 2
        push(2, 64'hA1, 1, 0); push(2, 64'hA2, 0, 0); push(2, 64'hA3, 0, 1);
        exp_q.push_back(64'hA1); exp_q.push_back(64'hA2); exp_q.push_back(64'hA3);
        cyc(); chk("sp_thx_idle", thx0, 4'b0000);
        cyc(); chk("sp_thx1", thx0, 4'b0100);
        cyc(); chk("sp_thx2", thx0, 4'b0100);
        cyc(); chk("sp_thx3", thx0, 4'b0100);
        cyc(); chk("sp_thx_done", thx0, 4'b0000);
        chk("sp_credit", c0, 1);
        yummy = 1'b1; repeat (3) cyc(); yummy = 1'b0;
        cyc(); chk("credit_refill", c0, 4);
        yummy = 1'b1; cyc(); yummy = 1'b0;
        cyc(); chk("credit_sat", c0, 4);

        // Round robin from reset; yummy held so forwards coincide with returns
        reset = 1'b1; cyc(); reset = 1'b0;
        push(0, 64'h10, 1, 1); push(0, 64'h11, 1, 1);
        push(1, 64'h20, 1, 1); push(2, 64'h30, 1, 1); push(3, 64'h40, 1, 1);
        exp_q.push_back(64'h10); exp_q.push_back(64'h20); exp_q.push_back(64'h30);
        exp_q.push_back(64'h40); exp_q.push_back(64'h11);
        yummy = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cyc();
            chk($sformatf("rr_thx%0d", k), thx0, rr_thx[k]);
            chk($sformatf("rr_credit%0d", k), c0, 4);
        end
        yummy = 1'b0;
        repeat (2) cyc();

        // Credit stall on the 2-credit port
        sel = 2'd1;
        push(1, 64'hB1, 1, 0); push(1, 64'hB2, 0, 0); push(1, 64'hB3, 0, 0); push(1, 64'hB4, 0, 1);
        exp_q.push_back(64'hB1); exp_q.push_back(64'hB2);
        exp_q.push_back(64'hB3); exp_q.push_back(64'hB4);
        cyc(); chk("cs_thx0", thx1, 4'b0000);
        cyc(); chk("cs_thx1", thx1, 4'b0010); chk("cs_stall1", st1, 0);
        cyc(); chk("cs_thx2", thx1, 4'b0010);
        cyc(); chk("cs_thx3", thx1, 4'b0000); chk("cs_stall3", st1, 1); chk("cs_credit0", c1, 0);
        cyc(); chk("cs_stall4", st1, 1);
        yummy = 1'b1;
        cyc(); yummy = 1'b0;
        chk("cs_release", thx1, 4'b0010); chk("cs_stall5", st1, 0);
        cyc(); chk("cs_stall6", st1, 1); chk("cs_thx6", thx1, 4'b0000);
        yummy = 1'b1;
        cyc(); yummy = 1'b0;
        chk("cs_release2", thx1, 4'b0010);
        cyc(); chk("cs_end_thx", thx1, 4'b0000); chk("cs_end_stall", st1, 0); chk("cs_end_credit", c1, 0);
        repeat (2) cyc();

        // Header kill with memory-ack / interrupt reporting
        sel = 2'd2;
        push(0, 64'hEA9400, 1, 1);
        exp_pop.push_back('{intr: 1'b0, snd: 10'h2A5});
        cyc(); chk("hk_thx0", thx2, 4'b0000);
        cyc(); chk("hk_thx1", thx2, 4'b0001); chk("hk_stall", st2, 0);
        cyc(); chk("hk_mem", pm2, 1); chk("hk_sender", sn2, 10'h2A5);
        chk("hk_int", pi2, 0); chk("hk_novalid", vo2, 0);
        cyc(); chk("hk_mem_clr", pm2, 0); chk("hk_sender_clr", sn2, 0); chk("hk_credit", c2, 4);
        push(1, 64'hF48C00, 1, 1);
        exp_pop.push_back('{intr: 1'b1, snd: 10'h0});
        cyc();
        cyc(); chk("hi_thx", thx2, 4'b0010);
        cyc(); chk("hi_int", pi2, 1); chk("hi_mem", pm2, 0); chk("hi_sender", sn2, 0);
        cyc(); chk("hi_int_clr", pi2, 0);
        push(2, 64'h0100_0000, 1, 0); push(2, 64'hC2, 0, 1);
        exp_q.push_back(64'hC2);
        cyc();
        cyc(); chk("hb_thx_hdr", thx2, 4'b0100);
        cyc(); chk("hb_thx_body", thx2, 4'b0100); chk("hb_nopop", {pi2, pm2}, 0);
        cyc(); chk("hb_credit", c2, 3);
        repeat (2) cyc();

        // Reset in the middle of a 4-flit packet on input 1
        sel = 2'd0;
        push(1, 64'hD1, 1, 0); push(1, 64'hD2, 0, 0); push(1, 64'hD3, 0, 0); push(1, 64'hD4, 0, 1);
        exp_q.push_back(64'hD1); exp_q.push_back(64'hD2);
        cyc();
        cyc(); chk("rm_thx1", thx0, 4'b0010);
        cyc(); chk("rm_thx2", thx0, 4'b0010);
        cyc();
        #2 reset = 1'b1;
        #1;
        chk("rm_valid", vo0, 0); chk("rm_data", do0, 0); chk("rm_credit", c0, 4);
        chk("rm_thx", thx0, 0); chk("rm_stall", st0, 0);
        txq[1].delete();
        cyc(); reset = 1'b0;
        push(3, 64'hE3, 1, 1); push(1, 64'hE1, 1, 1);
        exp_q.push_back(64'hE1); exp_q.push_back(64'hE3);
        cyc(); chk("rm_g_idle", thx0, 4'b0000);
        cyc(); chk("rm_g_first", thx0, 4'b0010);
        cyc(); chk("rm_g_gap", thx0, 4'b0000);
        cyc(); chk("rm_g_second", thx0, 4'b1000);
        repeat (3) cyc();

        chk("sb_flits_left", exp_q.size(), 0);
        chk("sb_pops_left", exp_pop.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
